// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and constants for the UART TX FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state (idle / packet transfer)
//   BYTE_W      : width of one ASCII byte
//   STALL_W     : width of the stall (timeout) counter
//   DEFAULT_TIMEOUT_CYC : stalled cycles allowed before a packet is aborted (1 ms at 100 MHz)
//   SRC_*       : requester index of each report source
package tx_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StXfer
    } arb_state_e;

    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned STALL_W             = 17;
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 100000;

    localparam int unsigned SRC_SONIC = 0;
    localparam int unsigned SRC_DHT   = 1;
    localparam int unsigned SRC_ECHO  = 2;

endpackage

// File: rtl/tx_fifo_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
//   req : request vector, one bit per source
//   ptr : round-robin pointer; the first set request at or after ptr (wrapping) wins
//   gnt : one-hot winner, all zero when no request is set
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: packet-level round-robin arbiter sharing the UART TX FIFO write port.
//   clk, reset       : 100 MHz clock, asynchronous active-low reset
//   req              : per-source packet pending (level)
//   src_data/valid/last : per-source byte stream, last marks the final byte of a packet
//   src_ready        : byte of the granted source accepted this cycle
//   fifo_full        : TX FIFO full flag
//   fifo_wdata/we    : FIFO write port, one byte per cycle
//   grant            : registered one-hot grant
//   busy             : a packet is in progress
//   timeout_err      : one-cycle pulse when a stalled packet is aborted
module tx_fifo_arbiter
    import tx_arb_pkg::*;
#(
    parameter int unsigned N_SRC       = 3,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        req,
    input  logic [BYTE_W*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC-1:0]        src_last,
    output logic [N_SRC-1:0]        src_ready,
    input  logic                    fifo_full,
    output logic [BYTE_W-1:0]       fifo_wdata,
    output logic                    fifo_we,
    output logic [N_SRC-1:0]        grant,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    arb_state_e          state_q, state_d;
    logic [N_SRC-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [STALL_W-1:0]  stall_q, stall_d;

    logic [N_SRC-1:0]    pick;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    ptr_after;
    logic                xfer;
    logic                last_sel;

    rr_pick #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (pick)
    );

    // Datapath: mux the granted source onto the FIFO port.
    always_comb begin
        xfer       = (state_q == StXfer);
        fifo_wdata = '0;
        grant_idx  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) begin
                fifo_wdata = src_data[BYTE_W*i +: BYTE_W];
                grant_idx  = PTR_W'(i);
            end
        end
        src_ready = (xfer && !fifo_full) ? grant_q : '0;
        fifo_we   = xfer && |(grant_q & src_valid) && !fifo_full;
        last_sel  = |(grant_q & src_last);
        ptr_after = (32'(grant_idx) == N_SRC - 1) ? '0 : grant_idx + PTR_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        stall_d     = stall_q;
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d = pick;
                    stall_d = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (fifo_we) begin
                    stall_d = '0;
                    if (last_sel) begin
                        state_d  = StIdle;
                        grant_d  = '0;
                        rr_ptr_d = ptr_after;
                    end
                end else if (stall_q >= STALL_W'(TIMEOUT_CYC)) begin
                    // Source or FIFO stuck: abort and move the pointer past the owner.
                    timeout_err = 1'b1;
                    state_d     = StIdle;
                    grant_d     = '0;
                    rr_ptr_d    = ptr_after;
                    stall_d     = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
        end
    end

    assign grant = grant_q;
    assign busy  = xfer;

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Testbench for tx_fifo_arbiter: packet-level reference model feeding a byte scoreboard,
// a monitor that pops and compares on every FIFO write, and source drivers fed by queues.
module tb_tx_fifo_arbiter;
    import tx_arb_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 20;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [N-1:0]       req = '0;
    logic [8*N-1:0]     src_data = '0;
    logic [N-1:0]       src_valid = '0;
    logic [N-1:0]       src_last = '0;
    logic [N-1:0]       src_ready;
    logic               fifo_full = 1'b0;
    logic [7:0]         fifo_wdata;
    logic               fifo_we;
    logic [N-1:0]       grant;
    logic               busy;
    logic               timeout_err;

    tx_fifo_arbiter #(
        .N_SRC       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .fifo_full   (fifo_full),
        .fifo_wdata  (fifo_wdata),
        .fifo_we     (fifo_we),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [8:0] srcq [N][$];   // driver queues: {last, byte}
    logic [8:0] mq   [N][$];   // model copy of pending packets
    logic [7:0] exp_q[$];      // expected FIFO byte stream
    bit         mute [N];
    bit         rand_valid = 0, rand_full = 0, force_full = 0;
    int         mptr = 0;
    int         exp_to = 0, obs_to = 0;
    int         wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input int s, input logic [7:0] b, input bit last);
        srcq[s].push_back({last, b});
        mq[s].push_back({last, b});
    endtask

    task automatic load_pkt(input int s, input int len);
        for (int j = 0; j < len; j++) push_byte(s, 8'($urandom_range(255)), j == len - 1);
    endtask

    // Packet-level round robin: every source with pending packets keeps requesting, so the
    // next owner is the first pending source at or after the pointer; muted owners time out.
    task automatic run_model();
        forever begin
            int s;
            logic [8:0] e;
            s = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (s < 0 && mq[c].size() > 0) s = c;
            end
            if (s < 0) break;
            do begin
                e = mq[s].pop_front();
                if (!mute[s]) exp_q.push_back(e[7:0]);
            end while (!e[8]);
            if (mute[s]) exp_to++;
            mptr = (s + 1) % N;
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = (srcq[0].size() == 0) && (srcq[1].size() == 0) && (srcq[2].size() == 0)
                && (exp_q.size() == 0) && (grant == '0) && (req == '0);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_idle: not idle, %0d bytes still expected", name, exp_q.size());
        end
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] want);
        bit seen;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = (grant != '0);
        end
        check(name, 32'(grant), 32'(want));
    endtask

    // Source drivers: present queued bytes, hold them until accepted.
    initial begin
        logic [N-1:0] acc_s, g_s;
        logic to_s;
        forever begin
            @(negedge clk);
            acc_s = src_valid & src_ready;
            g_s   = grant;
            to_s  = timeout_err;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_s[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (to_s && g_s[i]) srcq[i].delete();
                if (srcq[i].size() > 0) begin
                    req[i] = 1'b1;
                    if (mute[i]) src_valid[i] = 1'b0;
                    else if (!rand_valid || (src_valid[i] && !acc_s[i])) src_valid[i] = 1'b1;
                    else src_valid[i] = ($urandom_range(3) != 0);
                    src_data[8*i +: 8] = srcq[i][0][7:0];
                    src_last[i]        = srcq[i][0][8];
                end else begin
                    req[i]       = 1'b0;
                    src_valid[i] = 1'b0;
                    src_last[i]  = 1'b0;
                end
            end
            fifo_full = force_full | (rand_full && ($urandom_range(3) == 0));
        end
    end

    // Monitor: scoreboard pops on every FIFO write, plus per-cycle port rules.
    initial begin
        bit prev_last, prev_to;
        int gcyc;
        prev_last = 0;
        prev_to   = 0;
        gcyc      = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_last = 0;
                prev_to   = 0;
                gcyc      = 0;
            end else begin
                check("grant_onehot", 32'($onehot0(grant)), 32'd1);
                check("busy", 32'(busy), 32'(grant != '0));
                check("src_ready", 32'(src_ready), fifo_full ? 32'd0 : 32'(grant));
                check("fifo_we", 32'(fifo_we), 32'(((grant & src_valid) != '0) && !fifo_full));
                if (prev_last) check("gap_after_last", 32'(grant), 32'd0);
                if (prev_to) check("grant_after_timeout", 32'(grant), 32'd0);
                if (fifo_we) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got %02h required no write", fifo_wdata);
                    end else begin
                        check("fifo_wdata", 32'(fifo_wdata), 32'(exp_q.pop_front()));
                    end
                end
                prev_last = fifo_we && ((grant & src_last) != '0);
                gcyc      = (grant != '0) ? gcyc + 1 : 0;
                prev_to   = timeout_err;
                if (timeout_err) begin
                    obs_to++;
                    check("timeout_cycle", 32'(gcyc), 32'(TO + 1));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < N; i++) mute[i] = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(fifo_we), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        // All three request together: order 0,1,2 from pointer 0.
        @(posedge clk);
        #3;
        for (int s = 0; s < N; s++) load_pkt(s, 2);
        run_model();
        wait_grant("all3_first_grant", 3'b001);
        wait_idle("all3");

        // Single source "123\n": four back-to-back writes.
        @(posedge clk);
        #3;
        push_byte(0, 8'h31, 0);
        push_byte(0, 8'h32, 0);
        push_byte(0, 8'h33, 0);
        push_byte(0, 8'h0A, 1);
        run_model();
        wait_grant("t1_grant", 3'b001);
        check("t1_we0", 32'(fifo_we), 32'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("t1_we", 32'(fifo_we), 32'd1);
        end
        @(negedge clk);
        check("t1_grant_clear", 32'(grant), 32'd0);
        wait_idle("t1");

        // Backpressure mid-packet of source 1.
        @(posedge clk);
        #3;
        w0 = wr_cnt;
        load_pkt(1, 5);
        run_model();
        for (int c = 0; c < 50 && wr_cnt < w0 + 2; c++) begin
            @(posedge clk);
            #3;
        end
        force_full = 1;
        @(posedge clk);
        #3;
        w0 = wr_cnt;
        repeat (4) @(posedge clk);
        #3 force_full = 0;
        @(posedge clk);
        #3;
        check("bp_no_write_while_full", 32'(wr_cnt), 32'(w0));
        wait_idle("bp");

        // Timeout: source 0 requests but never sends; source 1 then gets the port.
        @(posedge clk);
        #3;
        mute[0] = 1;
        load_pkt(0, 3);
        load_pkt(1, 2);
        run_model();
        wait_idle("timeout");
        mute[0] = 0;

        // Randomized batches with random valid gaps and FIFO backpressure.
        rand_valid = 1;
        rand_full  = 1;
        for (int b = 0; b < 8; b++) begin
            @(posedge clk);
            #3;
            for (int s = 0; s < N; s++) begin
                int n;
                n = $urandom_range(3);
                for (int p = 0; p < n; p++) load_pkt(s, $urandom_range(1, 5));
            end
            run_model();
            wait_idle("random");
        end
        rand_valid = 0;
        rand_full  = 0;

        // Reset mid-packet after two of four bytes.
        @(posedge clk);
        #3;
        w0 = wr_cnt;
        push_byte(0, 8'h31, 0);
        push_byte(0, 8'h32, 0);
        push_byte(0, 8'h33, 0);
        push_byte(0, 8'h0A, 1);
        run_model();
        for (int c = 0; c < 50 && wr_cnt < w0 + 2; c++) begin
            @(posedge clk);
            #3;
        end
        reset = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_we", 32'(fifo_we), 32'd0);
        check("mid_rst_ready", 32'(src_ready), 32'd0);
        check("mid_rst_timeout", 32'(timeout_err), 32'd0);
        check("mid_rst_bytes_left", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        for (int s = 0; s < N; s++) srcq[s].delete();
        mptr = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #3;
        load_pkt(2, 2);
        run_model();
        wait_grant("post_rst_grant", 3'b100);
        wait_idle("post_rst");

        check("timeout_count", 32'(obs_to), 32'(exp_to));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
